// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control sequencer: control codes, MIPS funct
// and opcode values, alu_op classes and FSM states.
// Latency: n/a (constants only). Backpressure: n/a.
package alu_ctrl_pkg;

  // ALU control codes (4 significant bits, zero-extended to CTR_W at the top)
  localparam logic [3:0] CTR_AND  = 4'b0000;
  localparam logic [3:0] CTR_OR   = 4'b0001;
  localparam logic [3:0] CTR_ADD  = 4'b0010;
  localparam logic [3:0] CTR_XOR  = 4'b0011;
  localparam logic [3:0] CTR_NOR  = 4'b0100;
  localparam logic [3:0] CTR_SLTU = 4'b0101;
  localparam logic [3:0] CTR_SUB  = 4'b0110;
  localparam logic [3:0] CTR_SLT  = 4'b0111;
  localparam logic [3:0] CTR_SLL  = 4'b1000;
  localparam logic [3:0] CTR_SRL  = 4'b1001;
  localparam logic [3:0] CTR_SRA  = 4'b1010;
  localparam logic [3:0] CTR_LUI  = 4'b1011;
  localparam logic [3:0] CTR_MUL  = 4'b1100;
  localparam logic [3:0] CTR_DIV  = 4'b1101;

  // R-type funct field
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_SLLV  = 6'b000100;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_SRAV  = 6'b000111;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  // I-type opcodes
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  // alu_op classes from the main control unit
  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MD_BUSY = 1'b1
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Request/response bundle between the main control unit and the sequencer.
// Latency: n/a (wires only). Backpressure: in_valid/in_ready handshake.
// master = requester (drives flush/in_*), slave = alu_ctrl_seq.
interface alu_ctrl_seq_if #(
  parameter int CTR_W = 4
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [5:0]       opcode;
  logic [5:0]       func;
  logic             out_valid;
  logic [CTR_W-1:0] out_ctr;
  logic             out_shamt_var;
  logic             out_unsigned;
  logic             out_illegal;
  logic             md_busy;
  logic             md_done;

  modport master (
    output flush, in_valid, alu_op, opcode, func,
    input  in_ready, out_valid, out_ctr, out_shamt_var, out_unsigned,
           out_illegal, md_busy, md_done
  );

  modport slave (
    input  flush, in_valid, alu_op, opcode, func,
    output in_ready, out_valid, out_ctr, out_shamt_var, out_unsigned,
           out_illegal, md_busy, md_done
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decoder: {alu_op, opcode, func} -> control code+flags.
// Latency: 0 cycles (pure logic). Backpressure: none.
// Ports: alu_op_i/opcode_i/func_i in; ctr_o, shamt_var_o, unsigned_o, illegal_o, is_mul_o, is_div_o out.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] func_i,
  output logic [3:0] ctr_o,
  output logic       shamt_var_o,
  output logic       unsigned_o,
  output logic       illegal_o,
  output logic       is_mul_o,
  output logic       is_div_o
);

  always_comb begin
    // Unrecognised encodings fall through as AND with illegal set
    ctr_o       = CTR_AND;
    shamt_var_o = 1'b0;
    unsigned_o  = 1'b0;
    illegal_o   = 1'b0;
    is_mul_o    = 1'b0;
    is_div_o    = 1'b0;
    case (alu_op_i)
      ALUOP_MEM: ctr_o = CTR_ADD;
      ALUOP_BR:  ctr_o = CTR_SUB;
      ALUOP_R: begin
        case (func_i)
          F_ADD, F_ADDU: ctr_o = CTR_ADD;
          F_SUB, F_SUBU: ctr_o = CTR_SUB;
          F_AND:         ctr_o = CTR_AND;
          F_OR:          ctr_o = CTR_OR;
          F_XOR:         ctr_o = CTR_XOR;
          F_NOR:         ctr_o = CTR_NOR;
          F_SLT:         ctr_o = CTR_SLT;
          F_SLTU:        begin ctr_o = CTR_SLTU; unsigned_o = 1'b1; end
          F_SLL:         ctr_o = CTR_SLL;
          F_SLLV:        begin ctr_o = CTR_SLL; shamt_var_o = 1'b1; end
          F_SRL:         ctr_o = CTR_SRL;
          F_SRLV:        begin ctr_o = CTR_SRL; shamt_var_o = 1'b1; end
          F_SRA:         ctr_o = CTR_SRA;
          F_SRAV:        begin ctr_o = CTR_SRA; shamt_var_o = 1'b1; end
          F_MULT:        begin ctr_o = CTR_MUL; is_mul_o = 1'b1; end
          F_MULTU:       begin ctr_o = CTR_MUL; is_mul_o = 1'b1; unsigned_o = 1'b1; end
          F_DIV:         begin ctr_o = CTR_DIV; is_div_o = 1'b1; end
          F_DIVU:        begin ctr_o = CTR_DIV; is_div_o = 1'b1; unsigned_o = 1'b1; end
          default:       illegal_o = 1'b1;
        endcase
      end
      default: begin // ALUOP_I
        case (opcode_i)
          OP_ADDI, OP_ADDIU: ctr_o = CTR_ADD;
          OP_SLTI:           ctr_o = CTR_SLT;
          OP_SLTIU:          begin ctr_o = CTR_SLTU; unsigned_o = 1'b1; end
          OP_ANDI:           ctr_o = CTR_AND;
          OP_ORI:            ctr_o = CTR_OR;
          OP_XORI:           ctr_o = CTR_XOR;
          OP_LUI:            ctr_o = CTR_LUI;
          default:           illegal_o = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: registered decode behind valid/ready, MULT/DIV busy sequencing.
// Latency: 1 cycle request -> out_valid; md_busy spans MUL_CYCLES/DIV_CYCLES after issue.
// Backpressure: in_ready low while an MD sequence runs; flush aborts it synchronously.
// Ports: clk, rst_n (async active-low), bus (alu_ctrl_seq_if.slave); with ALU_CTRL_PERF_EN
// defined, also perf_issued/perf_md_stall/perf_illegal (PERF_W bits each).
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int CTR_W      = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
`ifdef ALU_CTRL_PERF_EN
  ,
  parameter int PERF_W     = 32
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_ctrl_seq_if.slave bus
`ifdef ALU_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_issued,
  output logic [PERF_W-1:0] perf_md_stall,
  output logic [PERF_W-1:0] perf_illegal
`endif
);

  localparam int MAX_CYC = max_int(MUL_CYCLES, DIV_CYCLES);
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  logic [3:0] dec_ctr;
  logic       dec_shamt_var, dec_unsigned, dec_illegal, dec_is_mul, dec_is_div;

  alu_ctrl_decode u_decode (
    .alu_op_i    (bus.alu_op),
    .opcode_i    (bus.opcode),
    .func_i      (bus.func),
    .ctr_o       (dec_ctr),
    .shamt_var_o (dec_shamt_var),
    .unsigned_o  (dec_unsigned),
    .illegal_o   (dec_illegal),
    .is_mul_o    (dec_is_mul),
    .is_div_o    (dec_is_div)
  );

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q, out_valid_q, md_busy_q, md_done_q;
  logic [CTR_W-1:0] ctr_q;
  logic             shamt_var_q, unsigned_q, illegal_q;

  logic             accept_d;
  logic [CNT_W-1:0] md_load_d;

  // in_ready_q is high exactly in IDLE, so it doubles as the state gate
  assign accept_d  = bus.in_valid && in_ready_q && !bus.flush;
  assign md_load_d = dec_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      md_busy_q   <= 1'b0;
      md_done_q   <= 1'b0;
      ctr_q       <= '0;
      shamt_var_q <= 1'b0;
      unsigned_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (bus.flush) begin
      // Abort: decoded fields keep their last value
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      md_busy_q   <= 1'b0;
      md_done_q   <= 1'b0;
    end else begin
      out_valid_q <= accept_d;
      md_done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            ctr_q       <= CTR_W'(dec_ctr);
            shamt_var_q <= dec_shamt_var;
            unsigned_q  <= dec_unsigned;
            illegal_q   <= dec_illegal;
            if (dec_is_mul || dec_is_div) begin
              state_q    <= ST_MD_BUSY;
              cnt_q      <= md_load_d;
              md_busy_q  <= 1'b1;
              in_ready_q <= 1'b0;
              // A one-cycle sequence finishes in its first busy cycle
              md_done_q  <= (md_load_d == '0);
            end
          end
        end
        ST_MD_BUSY: begin
          if (cnt_q == '0) begin
            state_q    <= ST_IDLE;
            md_busy_q  <= 1'b0;
            in_ready_q <= 1'b1;
          end else begin
            cnt_q     <= cnt_q - CNT_W'(1);
            // md_done is registered, so raise it as the counter lands on 0
            md_done_q <= (cnt_q == CNT_W'(1));
          end
        end
      endcase
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_ctr       = ctr_q;
  assign bus.out_shamt_var = shamt_var_q;
  assign bus.out_unsigned  = unsigned_q;
  assign bus.out_illegal   = illegal_q;
  assign bus.md_busy       = md_busy_q;
  assign bus.md_done       = md_done_q;

`ifdef ALU_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_issued_q, perf_md_stall_q, perf_illegal_q;

  // Free-running wrap-around counters; flush does not touch them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued_q   <= '0;
      perf_md_stall_q <= '0;
      perf_illegal_q  <= '0;
    end else begin
      if (accept_d)                        perf_issued_q   <= perf_issued_q + PERF_W'(1);
      if (bus.in_valid && !in_ready_q)     perf_md_stall_q <= perf_md_stall_q + PERF_W'(1);
      if (accept_d && dec_illegal)         perf_illegal_q  <= perf_illegal_q + PERF_W'(1);
    end
  end

  assign perf_issued   = perf_issued_q;
  assign perf_md_stall = perf_md_stall_q;
  assign perf_illegal  = perf_illegal_q;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: decode vector table plus MD sequencing,
// flush and asynchronous reset scenarios. Inputs change and outputs are sampled
// 1 time unit after the rising edge.
module tb_alu_ctrl_seq;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  alu_ctrl_seq_if #(.CTR_W(4)) bus ();

`ifdef ALU_CTRL_PERF_EN
  logic [3:0] perf_issued, perf_md_stall, perf_illegal;
`endif

  alu_ctrl_seq #(
    .CTR_W      (4),
    .MUL_CYCLES (4),
    .DIV_CYCLES (32)
`ifdef ALU_CTRL_PERF_EN
    ,
    .PERF_W     (4)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ALU_CTRL_PERF_EN
    ,
    .perf_issued   (perf_issued),
    .perf_md_stall (perf_md_stall),
    .perf_illegal  (perf_illegal)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  int m_busy, m_dones, m_at, m_rdy, m_ov, cnt;

  typedef struct {
    logic [1:0] alu_op;
    logic [5:0] opcode;
    logic [5:0] func;
    logic [3:0] ctr;
    logic       shamt;
    logic       uns;
    logic       ill;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk an MD busy window from the first busy cycle until md_busy drops (bounded).
  task automatic md_measure(output int busy, output int dones, output int done_at,
                            output int rdy_hi, output int ov);
    busy = 0; dones = 0; done_at = -1; rdy_hi = 0; ov = 0;
    for (int i = 0; i < 64; i++) begin
      if (!bus.md_busy) break;
      busy++;
      if (bus.md_done) begin dones++; done_at = busy; end
      if (bus.in_ready) rdy_hi++;
      if (i > 0 && bus.out_valid) ov++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //            alu_op  opcode     func       ctr      sh  un  il
    vecs[0]  = '{2'b00, 6'b000000, 6'b011010, 4'b0010, 0, 0, 0}; // LW/SW, func ignored
    vecs[1]  = '{2'b01, 6'b001111, 6'b000000, 4'b0110, 0, 0, 0}; // branch
    vecs[2]  = '{2'b10, 6'b000000, 6'b100111, 4'b0100, 0, 0, 0}; // NOR
    vecs[3]  = '{2'b10, 6'b000000, 6'b101011, 4'b0101, 0, 1, 0}; // SLTU
    vecs[4]  = '{2'b10, 6'b000000, 6'b000111, 4'b1010, 1, 0, 0}; // SRAV
    vecs[5]  = '{2'b10, 6'b000000, 6'b000000, 4'b1000, 0, 0, 0}; // SLL
    vecs[6]  = '{2'b10, 6'b000000, 6'b100001, 4'b0010, 0, 0, 0}; // ADDU
    vecs[7]  = '{2'b10, 6'b000000, 6'b101010, 4'b0111, 0, 0, 0}; // SLT
    vecs[8]  = '{2'b11, 6'b001111, 6'b000000, 4'b1011, 0, 0, 0}; // LUI
    vecs[9]  = '{2'b11, 6'b001011, 6'b000000, 4'b0101, 0, 1, 0}; // SLTIU
    vecs[10] = '{2'b11, 6'b001110, 6'b000000, 4'b0011, 0, 0, 0}; // XORI
    vecs[11] = '{2'b11, 6'b000010, 6'b011010, 4'b0000, 0, 0, 1}; // J opcode: illegal
    vecs[12] = '{2'b10, 6'b000000, 6'b111111, 4'b0000, 0, 0, 1}; // bad funct

    bus.flush = 1'b0; bus.in_valid = 1'b0;
    bus.alu_op = 2'b00; bus.opcode = 6'd0; bus.func = 6'd0;
    rst_n = 1'b0;
    tick(); tick();
    chk("reset in_ready",  bus.in_ready, 1);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset out_ctr",   bus.out_ctr, 0);
    chk("reset md_busy",   bus.md_busy, 0);
    chk("reset md_done",   bus.md_done, 0);
    chk("reset illegal",   bus.out_illegal, 0);
    #3 rst_n = 1'b1;
    tick();
    chk("post-reset out_valid", bus.out_valid, 0);

    // Decode table: accept, check pulse and fields, then check hold with idle inputs
    for (int i = 0; i < 13; i++) begin
      bus.in_valid = 1'b1;
      bus.alu_op = vecs[i].alu_op; bus.opcode = vecs[i].opcode; bus.func = vecs[i].func;
      tick();
      chk($sformatf("vec%0d out_valid", i), bus.out_valid, 1);
      chk($sformatf("vec%0d out_ctr", i), bus.out_ctr, vecs[i].ctr);
      chk($sformatf("vec%0d shamt_var", i), bus.out_shamt_var, vecs[i].shamt);
      chk($sformatf("vec%0d unsigned", i), bus.out_unsigned, vecs[i].uns);
      chk($sformatf("vec%0d illegal", i), bus.out_illegal, vecs[i].ill);
      bus.in_valid = 1'b0;
      bus.alu_op = 2'b10; bus.func = 6'b100101; bus.opcode = 6'b001101;
      tick();
      chk($sformatf("vec%0d pulse end", i), bus.out_valid, 0);
      chk($sformatf("vec%0d ctr hold", i), bus.out_ctr, vecs[i].ctr);
      chk($sformatf("vec%0d no md_busy", i), bus.md_busy, 0);
    end

    // DIV: 32 busy cycles, one md_done, requests held off, next one accepted after done
    bus.alu_op = 2'b10; bus.func = 6'b011010; bus.in_valid = 1'b1;
    tick();
    chk("div out_valid", bus.out_valid, 1);
    chk("div out_ctr",   bus.out_ctr, 4'b1101);
    chk("div md_busy",   bus.md_busy, 1);
    chk("div in_ready",  bus.in_ready, 0);
    bus.alu_op = 2'b00; // ADD request stays asserted throughout
    md_measure(m_busy, m_dones, m_at, m_rdy, m_ov);
    chk("div busy cycles", m_busy, 32);
    chk("div md_done count", m_dones, 1);
    chk("div md_done position", m_at, 32);
    chk("div in_ready while busy", m_rdy, 0);
    chk("div out_valid while busy", m_ov, 0);
    chk("div in_ready after done", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("after div out_valid", bus.out_valid, 1);
    chk("after div out_ctr", bus.out_ctr, 4'b0010);
    tick();

    // MULTU runs the full 4-cycle window
    bus.alu_op = 2'b10; bus.func = 6'b011001; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("multu out_ctr", bus.out_ctr, 4'b1100);
    chk("multu unsigned", bus.out_unsigned, 1);
    md_measure(m_busy, m_dones, m_at, m_rdy, m_ov);
    chk("mul busy cycles", m_busy, 4);
    chk("mul md_done count", m_dones, 1);
    chk("mul md_done position", m_at, 4);

    // MULT flushed on busy cycle 2
    bus.alu_op = 2'b10; bus.func = 6'b011000; bus.in_valid = 1'b1;
    tick();                       // busy cycle 1
    bus.in_valid = 1'b0;
    tick();                       // busy cycle 2
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.alu_op = 2'b00;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush md_busy", bus.md_busy, 0);
    chk("flush md_done", bus.md_done, 0);
    chk("flush out_valid", bus.out_valid, 0);
    chk("flush in_ready", bus.in_ready, 1);
    chk("flush ctr hold", bus.out_ctr, 4'b1100);
    bus.in_valid = 1'b1; bus.alu_op = 2'b00;
    tick();
    bus.in_valid = 1'b0;
    chk("post-flush add valid", bus.out_valid, 1);
    chk("post-flush add ctr", bus.out_ctr, 4'b0010);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.md_done) cnt++;
      tick();
    end
    chk("flush no late md_done", cnt, 0);

    // Flush beats a request in IDLE
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.alu_op = 2'b01;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("idle flush out_valid", bus.out_valid, 0);
    chk("idle flush ctr hold", bus.out_ctr, 4'b0010);

    // Flush in the cycle before the counter lands on 0: no md_done at all
    bus.alu_op = 2'b10; bus.func = 6'b011000; bus.in_valid = 1'b1;
    tick();                       // cnt 3
    bus.in_valid = 1'b0;
    tick();                       // cnt 2
    tick();                       // cnt 1
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("late flush md_busy", bus.md_busy, 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.md_done) cnt++;
      tick();
    end
    chk("late flush md_done", cnt, 0);
    chk("late flush in_ready", bus.in_ready, 1);

    // Asynchronous reset in the middle of a DIV
    bus.alu_op = 2'b10; bus.func = 6'b011011; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    chk("pre-reset md_busy", bus.md_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst out_valid", bus.out_valid, 0);
    chk("arst out_ctr", bus.out_ctr, 0);
    chk("arst md_busy", bus.md_busy, 0);
    chk("arst md_done", bus.md_done, 0);
    chk("arst unsigned", bus.out_unsigned, 0);
    chk("arst in_ready", bus.in_ready, 1);
`ifdef ALU_CTRL_PERF_EN
    chk("arst perf_issued", perf_issued, 0);
`endif
    #3 rst_n = 1'b1;
    tick(); tick();
    chk("after arst md_busy", bus.md_busy, 0);
    chk("after arst md_done", bus.md_done, 0);

`ifdef ALU_CTRL_PERF_EN
    // 17 back-to-back issues wrap the 4-bit counter to 1
    bus.in_valid = 1'b1; bus.alu_op = 2'b00;
    repeat (17) tick();
    bus.in_valid = 1'b0;
    chk("perf_issued wrap", perf_issued, 1);
    bus.in_valid = 1'b1; bus.alu_op = 2'b11; bus.opcode = 6'b000010;
    tick();
    chk("perf_illegal", perf_illegal, 1);
    bus.alu_op = 2'b10; bus.func = 6'b011010;
    tick();                       // DIV accepted
    repeat (3) tick();            // three stalled cycles
    bus.in_valid = 1'b0;
    chk("perf_md_stall", perf_md_stall, 3);
    chk("perf_issued total", perf_issued, 3);
    md_measure(m_busy, m_dones, m_at, m_rdy, m_ov);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
Parametrised successor to the two-bit ALUOp/funct ALU control decoder. Decodes the full MIPS R-type funct set and the I-type ALU opcodes into a widened ALUctr code, and registers the result behind a valid/ready handshake. Sequences multi-cycle MULT/DIV operations with a busy counter that holds off new issues. Sits between the main control unit and the ALU/MDU in the mips_core datapath.

Parameters:
CTR_W, 4, width of out_ctr; legal range is 4 or more, upper bits zero-filled.
MUL_CYCLES, 4, cycles md_busy stays high for MULT/MULTU; range 1 or more.
DIV_CYCLES, 32, cycles md_busy stays high for DIV/DIVU; range 1 or more.
PERF_W, 32, width of the performance counters (ALU_CTRL_PERF_EN only).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous abort of the in-flight issue or MD sequence.
in_valid  in  1  decode request.
in_ready  out  1  block can accept a request this cycle.
alu_op  in  2  00 = load/store, 01 = branch, 10 = R-type, 11 = I-type.
opcode  in  6  instruction[31:26]; used when alu_op is 11.
func  in  6  instruction[5:0]; used when alu_op is 10.
out_valid  out  1  one-cycle pulse per accepted request.
out_ctr  out  CTR_W  ALU control code.
out_shamt_var  out  1  shift amount comes from rs (SLLV, SRLV, SRAV).
out_unsigned  out  1  unsigned variant (SLTU, SLTIU, MULTU, DIVU).
out_illegal  out  1  unrecognised encoding; valid with out_valid.
md_busy  out  1  MULT/DIV sequence in progress.
md_done  out  1  one-cycle pulse at the end of the MD sequence.

Behaviour:
- Reset values: state IDLE; in_ready 1; every other output and counter 0.
- Control codes (shown zero-extended to CTR_W):
  - AND 0000, OR 0001, ADD 0010, XOR 0011, NOR 0100, SLTU 0101, SUB 0110, SLT 0111.
  - SLL 1000, SRL 1001, SRA 1010, LUI 1011, MUL 1100, DIV 1101.
- Decode for alu_op = 00 (load/store) and 01 (branch):
  - 00 gives ADD; 01 gives SUB. func and opcode are ignored.
- Decode for alu_op = 10 (R-type), by func:
  - 100000/100001 ADD; 100010/100011 SUB.
  - 100100 AND; 100101 OR; 100110 XOR; 100111 NOR.
  - 101010 SLT; 101011 SLTU.
  - 000000/000100 SLL; 000010/000110 SRL; 000011/000111 SRA; the second code of each pair sets out_shamt_var.
  - 011000/011001 MUL; 011010/011011 DIV.
- Decode for alu_op = 11 (I-type), by opcode:
  - 001000/001001 ADD; 001010 SLT; 001011 SLTU.
  - 001100 AND; 001101 OR; 001110 XOR; 001111 LUI.
- Illegal encodings: any other func or opcode gives out_ctr = AND and out_illegal = 1. No MD sequence is started.
- FSM states: IDLE, MD_BUSY.
- IDLE:
  - in_ready = 1.
  - A request is accepted when in_valid is high. Decoded outputs are registered, and out_valid pulses the next cycle (latency 1).
  - A MUL or DIV decode moves to MD_BUSY. The counter loads MUL_CYCLES-1 or DIV_CYCLES-1, and md_busy rises in the same cycle as out_valid.
- MD_BUSY:
  - in_ready = 0; in_valid is ignored.
  - The counter decrements each cycle.
  - In the cycle the counter is 0: md_done = 1, md_busy = 0 on the next edge, and the state returns to IDLE.
  - in_ready is high again in the cycle after md_done.
- out_ctr, out_shamt_var, out_unsigned and out_illegal hold their last value between out_valid pulses.
- flush:
  - Wins over in_valid in the same cycle; no request is accepted.
  - Next edge: state IDLE, counter 0, out_valid 0, md_busy 0. No md_done is produced.
  - Held-value outputs are unchanged.
- When flush coincides with the counter reaching 0, flush wins: md_done stays 0.
- When rst_n is asserted mid-sequence, all state and outputs immediately take their reset values.

Optional Feature:
ALU_CTRL_PERF_EN
- Defined: adds output ports perf_issued, perf_md_stall and perf_illegal, each PERF_W bits.
  - perf_issued counts accepted requests.
  - perf_md_stall counts cycles with in_valid high and in_ready low.
  - perf_illegal counts illegal decodes.
  - Counters wrap modulo 2^PERF_W, reset to 0, and are unaffected by flush.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package alu_ctrl_pkg holds:
  - the control-code localparams;
  - the funct and opcode localparams;
  - the alu_op encodings;
  - the FSM state encoding.
- Sub-module alu_ctrl_decode is purely combinational: {alu_op, opcode, func} in; ctr, shamt_var, unsigned, illegal and is_mul/is_div out.
- The top level holds the registers, FSM, counter and perf counters.

Test Plan:
- Reset release, alu_op=00, in_valid=1 → one cycle later out_valid=1 and out_ctr=0010; alu_op=01 → out_ctr=0110.
- alu_op=10 with func 100111, 101011, 000111 → out_ctr 0100; 0101 with out_unsigned=1; 1010 with out_shamt_var=1.
- alu_op=10, func=011010, DIV_CYCLES=32:
  - md_busy is high for exactly 32 cycles;
  - md_done pulses once;
  - in_ready stays low throughout the busy window even with in_valid held high;
  - the next request is accepted in the cycle after md_done.
- alu_op=11, opcode=001111 → out_ctr=1011; opcode=000010 → out_illegal=1, out_ctr=0000, md_busy stays 0.
- MULT accepted, flush on busy cycle 2:
  - md_busy=0 next cycle, no md_done;
  - an ADD issued the following cycle produces out_ctr=0010.
- With ALU_CTRL_PERF_EN and PERF_W=4, issue 17 requests → perf_issued=1; assert rst_n low mid-DIV → all outputs 0 asynchronously.
